prio_tag_arbiter: RTL

// - Writer-side front end for fifo_priority: merges a high-priority and a low-priority source into one
//   DW-bit valid/ready stream, tagging bit [DW-1] with priority (1=high, 0=low).
// - Arbitrates between the sources with a bounded-starvation rule so low traffic always progresses.
// - Drives the output from a one-entry register slice; output feeds fifo_priority data_in/vld_i/rdy_o.

---
 rtl/prio_pkg.sv | 16 +
 rtl/prio_reg_slice.sv | 29 ++
 rtl/prio_tag_arbiter.sv | 67 ++++++
 3 files changed

// File: rtl/prio_pkg.sv
// Shared definitions for the priority-tagged stream: default word width, tag values
// and the {tag, payload} word layout also used on the fifo_priority side.
package prio_pkg;

   localparam int unsigned DW = 33;
   localparam int unsigned PW = DW - 1;

   localparam logic PRIO_HI = 1'b1;
   localparam logic PRIO_LO = 1'b0;

   typedef struct packed {
      logic          prio;
      logic [PW-1:0] payload;
   } prio_word_t;

endpackage

// File: rtl/prio_reg_slice.sv
// One-entry valid/ready register slice; accepts a new word whenever it is empty
// or its current word leaves this cycle, so it sustains one word per cycle.
module prio_reg_slice #(
   parameter int unsigned DW = 33
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] in_data,
   input  logic          in_vld,
   output logic          in_rdy_c,
   output logic [DW-1:0] out_data,
   output logic          out_vld,
   input  logic          out_rdy
);

   assign in_rdy_c = !out_vld || out_rdy;

   // data_out keeps its last value when the slot empties
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_vld  <= 1'b0;
         out_data <= '0;
      end else if (in_rdy_c) begin
         out_vld <= in_vld;
         if (in_vld) out_data <= in_data;
      end
   end

endmodule

// File: rtl/prio_tag_arbiter.sv
// Merges a high- and a low-priority source into one tagged valid/ready stream,
// with a bounded number of high grants while low waits.
module prio_tag_arbiter
   import prio_pkg::*;
#(
   parameter int unsigned DW         = prio_pkg::DW,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-2:0] hi_data_i,
   input  logic          hi_vld_i,
   output logic          hi_rdy_o,
   input  logic [DW-2:0] lo_data_i,
   input  logic          lo_vld_i,
   output logic          lo_rdy_o,
   output logic [DW-1:0] data_out,
   output logic          vld_o,
   input  logic          rdy_i
);

   localparam int unsigned CW = $clog2(STARVE_MAX + 1);

   logic          load_en_c;
   logic          grant_hi_c;
   logic          grant_lo_c;
   logic [DW-1:0] slot_data_c;
   logic          slot_vld_c;
   logic [CW-1:0] starve_cnt;

   assign grant_hi_c = hi_vld_i && (!lo_vld_i || (starve_cnt < CW'(STARVE_MAX)));
   assign grant_lo_c = lo_vld_i && !grant_hi_c;

   // rst gating keeps both ready outputs low while the slot is held in reset
   assign hi_rdy_o = rst && load_en_c && grant_hi_c;
   assign lo_rdy_o = rst && load_en_c && grant_lo_c;

   assign slot_vld_c  = hi_rdy_o || lo_rdy_o;
   assign slot_data_c = grant_hi_c ? {PRIO_HI, hi_data_i} : {PRIO_LO, lo_data_i};

   // consecutive high grants taken while low was waiting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (load_en_c) begin
         if (grant_hi_c && lo_vld_i) begin
            if (starve_cnt != CW'(STARVE_MAX)) starve_cnt <= starve_cnt + CW'(1);
         end else begin
            starve_cnt <= '0;
         end
      end
   end

   prio_reg_slice #(
      .DW (DW)
   ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .in_data  (slot_data_c),
      .in_vld   (slot_vld_c),
      .in_rdy_c (load_en_c),
      .out_data (data_out),
      .out_vld  (vld_o),
      .out_rdy  (rdy_i)
   );

endmodule
